// File: rtl/lane_word_streamer_if.sv
// Request/response bundle between the cache data-array read stage and the
// lane word streamer. The master issues lane requests and consumes beats.
interface lane_word_streamer_if #(
  parameter int LOG_WAYS    = 2,
  parameter int OFFSET_BITS = 3
);
  localparam int LANE_W = 8 * (2**OFFSET_BITS) * (2**LOG_WAYS);

  logic                   req_valid;
  logic                   req_ready;
  logic [LANE_W-1:0]      req_lane;
  logic [LOG_WAYS-1:0]    req_pos;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [OFFSET_BITS-3:0] req_burst_len;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [31:0]            rsp_data;
  logic                   rsp_last;
  logic                   rsp_err;

  modport master (
    output req_valid, req_lane, req_pos, req_offset, req_size, req_unsigned,
           req_burst_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_lane, req_pos, req_offset, req_size, req_unsigned,
           req_burst_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
  );
endinterface

// File: rtl/lane_word_streamer.sv
// Lane word streamer: captures one way of a cache lane and returns either a
// single extended byte/half/word or a critical-word-first wrapping burst of
// words from that way, one beat per cycle under valid/ready flow control.
module lane_word_streamer #(
  parameter int LOG_WAYS    = 2,
  parameter int OFFSET_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  lane_word_streamer_if.slave   bus
);
  localparam int WAY_W = 8 * (2**OFFSET_BITS);
  localparam int IDX_W = OFFSET_BITS - 2;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             r_state;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_last;
  logic               r_rsp_err;
  logic [31:0]        r_rsp_data;
  logic [WAY_W-1:0]   r_way;
  logic [IDX_W-1:0]   r_word_idx;
  logic [IDX_W-1:0]   r_beat;
  logic [IDX_W-1:0]   r_burst_len;

  logic               w_accept;
  logic               w_misaligned;
  logic               w_single;
  logic [WAY_W-1:0]   w_sel_way;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_word;
  logic [31:0]        w_first_data;
  logic [IDX_W-1:0]   w_next_beat;
  logic [31:0]        w_next_data;

  assign w_accept  = bus.req_valid && r_req_ready;
  assign w_sel_way = bus.req_lane[bus.req_pos*WAY_W +: WAY_W];

  // Half needs offset[0]=0, word needs offset[1:0]=0; reserved size acts as word.
  assign w_misaligned = ((bus.req_size == 2'b01) && bus.req_offset[0]) ||
                        (bus.req_size[1] && (bus.req_offset[1:0] != 2'b00));
  assign w_single     = !bus.req_size[1] || w_misaligned;

  // Aligned selects keep every part-select inside the way even when the
  // request turns out misaligned (its data is then discarded).
  assign w_byte = w_sel_way[{bus.req_offset, 3'b000} +: 8];
  assign w_half = w_sel_way[{bus.req_offset[OFFSET_BITS-1:1], 4'b0000} +: 16];
  assign w_word = w_sel_way[{bus.req_offset[OFFSET_BITS-1:2], 5'b00000} +: 32];

  // First-beat data: extend byte/half or pass the word straight through.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    w_first_data = w_word;
    case (bus.req_size)
      2'b00:   w_first_data = bus.req_unsigned ? {24'b0, w_byte}
                                               : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_first_data = bus.req_unsigned ? {16'b0, w_half}
                                               : {{16{w_half[15]}}, w_half};
      default: w_first_data = w_word;
    endcase
  end

  // Following burst beat: the index sum wraps naturally within the way.
  assign w_next_beat = r_beat + 1'b1;
  assign w_next_data = r_way[{r_word_idx + w_next_beat, 5'b00000} +: 32];

  // Capture the selected way on accept so the lane input is free afterwards.
  // NOTE: pure data register, qualified by r_rsp_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_way <= w_sel_way;
  end

  // Request/stream FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_word_idx  <= '0;
      r_beat      <= '0;
      r_burst_len <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_STREAM;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_beat      <= '0;
            r_word_idx  <= bus.req_offset[OFFSET_BITS-1:2];
            r_burst_len <= w_single ? '0 : bus.req_burst_len;
            r_rsp_err   <= w_misaligned;
            r_rsp_last  <= w_single || (bus.req_burst_len == '0);
            r_rsp_data  <= w_misaligned ? 32'h0 : w_first_data;
          end
        end
        S_STREAM: begin
          if (bus.rsp_ready) begin
            if (r_rsp_last) begin
              r_state     <= S_IDLE;
              r_rsp_valid <= 1'b0;
              r_req_ready <= 1'b1;
            end else begin
              r_beat     <= w_next_beat;
              r_rsp_data <= w_next_data;
              r_rsp_last <= (w_next_beat == r_burst_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_lane_word_streamer.sv
// Bench for lane_word_streamer: one instance with 8-byte ways and one with
// 16-byte ways, sharing stimulus; beats are compared with a byte-level model.
module tb_lane_word_streamer;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         sel;
  logic [511:0] t_lane;
  logic [1:0]   t_pos;
  logic [3:0]   t_off;
  logic [1:0]   t_size;
  logic         t_uns;
  logic [1:0]   t_bl;
  logic         t_valid;
  logic         t_rready;

  int           n_total = 0;
  int           n_bad   = 0;
  beat_t        exp_q[$];
  logic [31:0]  first_data;
  int           beats_seen;
  int           cycles_seen;

  always #5 clk = ~clk;

  lane_word_streamer_if #(.LOG_WAYS(2), .OFFSET_BITS(3)) b3 ();
  lane_word_streamer_if #(.LOG_WAYS(2), .OFFSET_BITS(4)) b4 ();

  lane_word_streamer #(.LOG_WAYS(2), .OFFSET_BITS(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));
  lane_word_streamer #(.LOG_WAYS(2), .OFFSET_BITS(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

  assign b3.req_valid     = t_valid && !sel;
  assign b3.req_lane      = t_lane[255:0];
  assign b3.req_pos       = t_pos;
  assign b3.req_offset    = t_off[2:0];
  assign b3.req_size      = t_size;
  assign b3.req_unsigned  = t_uns;
  assign b3.req_burst_len = t_bl[0:0];
  assign b3.rsp_ready     = t_rready;

  assign b4.req_valid     = t_valid && sel;
  assign b4.req_lane      = t_lane;
  assign b4.req_pos       = t_pos;
  assign b4.req_offset    = t_off;
  assign b4.req_size      = t_size;
  assign b4.req_unsigned  = t_uns;
  assign b4.req_burst_len = t_bl;
  assign b4.rsp_ready     = t_rready;

  logic        w_req_ready, w_rsp_valid, w_rsp_last, w_rsp_err;
  logic [31:0] w_rsp_data;
  assign w_req_ready = sel ? b4.req_ready : b3.req_ready;
  assign w_rsp_valid = sel ? b4.rsp_valid : b3.rsp_valid;
  assign w_rsp_last  = sel ? b4.rsp_last  : b3.rsp_last;
  assign w_rsp_err   = sel ? b4.rsp_err   : b3.rsp_err;
  assign w_rsp_data  = sel ? b4.rsp_data  : b3.rsp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] lb(input logic [511:0] lane, input int idx);
    return lane[idx*8 +: 8];
  endfunction

  // Expected beats from byte-addressed lane contents and the request fields.
  function automatic void model(input bit s, input logic [511:0] lane, input int pos,
                                input int off, input int size, input bit uns, input int bl);
    int bpw, nw, base, w;
    logic [31:0] v;
    bpw  = s ? 16 : 8;
    nw   = bpw / 4;
    base = pos * bpw;
    exp_q.delete();
    if ((size == 1 && off % 2 != 0) || (size >= 2 && off % 4 != 0)) begin
      exp_q.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
    end else if (size == 0) begin
      v = {24'h0, lb(lane, base + off)};
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      exp_q.push_back('{data: v, last: 1'b1, err: 1'b0});
    end else if (size == 1) begin
      v = {16'h0, lb(lane, base + off + 1), lb(lane, base + off)};
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
      exp_q.push_back('{data: v, last: 1'b1, err: 1'b0});
    end else begin
      for (int k = 0; k <= bl; k++) begin
        w = base + 4 * ((off / 4 + k) % nw);
        v = {lb(lane, w + 3), lb(lane, w + 2), lb(lane, w + 1), lb(lane, w)};
        exp_q.push_back('{data: v, last: (k == bl), err: 1'b0});
      end
    end
  endfunction

  // mode 0: random rsp_ready, 1: always ready, 2: stall 3 cycles on second beat
  task automatic run_req(input bit s, input logic [511:0] lane, input int pos, input int off,
                         input int size, input bit uns, input int bl, input int mode);
    beat_t       e;
    int          guard, nb, cycles, stall;
    bit          held, r;
    logic [31:0] hd;
    logic        hl, he;
    sel = s;
    model(s, lane, pos, off, size, uns, bl);
    @(negedge clk);
    guard = 0;
    while (!w_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_accept", w_req_ready, 1);
    t_lane = lane; t_pos = 2'(pos); t_off = 4'(off); t_size = 2'(size);
    t_uns = uns; t_bl = 2'(bl); t_valid = 1'b1; t_rready = 1'b0;
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    for (int j = 0; j < 16; j++) t_lane[j*32 +: 32] = $urandom;
    @(negedge clk);
    check("first_beat_latency", w_rsp_valid, 1);
    nb = 0; cycles = 0; stall = 0; held = 0;
    hd = '0; hl = 1'b0; he = 1'b0;
    while (exp_q.size() > 0 && cycles < 200) begin
      check("rsp_valid_in_request", w_rsp_valid, 1);
      if (held) begin
        check("held_data", w_rsp_data, hd);
        check("held_last", w_rsp_last, hl);
        check("held_err",  w_rsp_err,  he);
      end
      if (mode == 1) r = 1'b1;
      else if (mode == 2) begin
        if (nb == 1 && stall < 3) begin r = 1'b0; stall++; end
        else r = 1'b1;
      end else r = ($urandom_range(0, 3) != 0);
      t_rready = r;
      if (w_rsp_valid && r) begin
        e = exp_q.pop_front();
        if (nb == 0) first_data = w_rsp_data;
        check("beat_data", w_rsp_data, e.data);
        check("beat_last", w_rsp_last, e.last);
        check("beat_err",  w_rsp_err,  e.err);
        nb++;
        held = 0;
      end else if (w_rsp_valid) begin
        held = 1; hd = w_rsp_data; hl = w_rsp_last; he = w_rsp_err;
      end
      @(negedge clk);
      cycles++;
    end
    check("beats_outstanding", exp_q.size(), 0);
    t_rready = 1'b0;
    check("valid_after_last", w_rsp_valid, 0);
    check("ready_after_last", w_req_ready, 1);
    beats_seen  = nb;
    cycles_seen = cycles;
  endtask

  initial begin
    logic [511:0] lane;
    logic [511:0] lane_a;
    int s, bpw, size, off;

    reset = 1'b1; sel = 1'b0; t_lane = '0; t_pos = '0; t_off = '0; t_size = '0;
    t_uns = 1'b0; t_bl = '0; t_valid = 1'b0; t_rready = 1'b0;
    first_data = '0; beats_seen = 0; cycles_seen = 0;
    #12 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check("reset_rsp_valid", w_rsp_valid, 0);
      check("reset_req_ready", w_req_ready, 1);
      check("reset_rsp_data",  w_rsp_data,  0);
      check("reset_rsp_last",  w_rsp_last,  0);
      check("reset_rsp_err",   w_rsp_err,   0);
    end

    // 8-byte ways, lane byte i = i
    lane = '0;
    for (int i = 0; i < 32; i++) lane[i*8 +: 8] = 8'(i);
    run_req(0, lane, 2, 4, 2, 0, 0, 1);
    check("word_pos2_off4", first_data, 32'h1716_1514);
    check("word_single_beats", beats_seen, 1);

    lane[13*8 +: 8] = 8'h85;
    lane[12*8 +: 8] = 8'h0C;
    run_req(0, lane, 1, 5, 0, 0, 0, 1);
    check("byte_signed", first_data, 32'hFFFF_FF85);
    run_req(0, lane, 1, 5, 0, 1, 0, 1);
    check("byte_unsigned", first_data, 32'h0000_0085);
    run_req(0, lane, 1, 4, 1, 0, 1, 1);
    check("half_signed", first_data, 32'hFFFF_850C);
    run_req(0, lane, 1, 2, 2, 0, 1, 1);
    check("word_misaligned_data", first_data, 32'h0);
    run_req(0, lane, 1, 1, 1, 0, 0, 1);
    check("half_misaligned_data", first_data, 32'h0);
    run_req(0, lane, 3, 4, 3, 1, 1, 1);
    check("reserved_size_wrap_beats", beats_seen, 2);

    // 16-byte ways, way0 words A0..A3
    lane_a = '0;
    for (int i = 0; i < 4; i++) lane_a[i*32 +: 32] = 32'hA0 + 32'(i);
    run_req(1, lane_a, 0, 8, 2, 0, 3, 1);
    check("burst_first_word", first_data, 32'hA2);
    check("burst_beats", beats_seen, 4);
    check("burst_back_to_back_cycles", cycles_seen, 4);
    run_req(1, lane_a, 0, 8, 2, 0, 3, 2);
    check("stall_burst_beats", beats_seen, 4);
    check("stall_burst_cycles", cycles_seen, 7);
    run_req(1, lane_a, 0, 0, 2, 0, 3, 1);
    check("full_way_beats", beats_seen, 4);

    // asynchronous reset in the middle of a burst
    sel = 1'b1;
    @(negedge clk);
    t_lane = lane_a; t_pos = 2'd0; t_off = 4'd8; t_size = 2'd2; t_bl = 2'd3;
    t_uns = 1'b0; t_valid = 1'b1; t_rready = 1'b1;
    @(posedge clk);
    #1 t_valid = 1'b0;
    @(negedge clk);
    check("mid_reset_beat0", w_rsp_data, 32'hA2);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_reset_valid_low", w_rsp_valid, 0);
    check("mid_reset_data_zero", w_rsp_data, 0);
    @(negedge clk);
    reset = 1'b0;
    t_rready = 1'b0;
    #1;
    check("post_reset_req_ready", w_req_ready, 1);
    check("post_reset_valid", w_rsp_valid, 0);
    run_req(1, lane_a, 0, 4, 2, 0, 2, 1);
    check("post_reset_first_word", first_data, 32'hA1);
    check("post_reset_beats", beats_seen, 3);

    // randomized requests on both configurations
    for (int n = 0; n < 80; n++) begin
      s    = $urandom_range(0, 1);
      bpw  = s ? 16 : 8;
      for (int j = 0; j < 16; j++) lane[j*32 +: 32] = $urandom;
      size = $urandom_range(0, 3);
      off  = $urandom_range(0, bpw - 1);
      if ($urandom_range(0, 3) != 0) begin
        if (size == 1) off = off & ~1;
        else if (size >= 2) off = off & ~3;
      end
      run_req(s[0], lane, $urandom_range(0, 3), off, size, $urandom_range(0, 1) != 0,
              $urandom_range(0, s ? 3 : 1), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/lane_word_streamer.md
Name:
lane_word_streamer

Overview:
- Sequential, handshaked successor to the combinational way/word selector in the cache read path.
- Accepts a request carrying a full cache lane (all ways), a way select and a byte offset.
- Supports byte/half/word loads with sign or zero extension, plus wrap-around multi-word bursts (critical-word-first line streaming) from the selected way.
- Sits between the cache tag/data array read stage and the core load-return / refill-forward path.

Parameters:
- LOG_WAYS, 2, log2 of ways packed in the lane input (way = 8*2^OFFSET_BITS bits).
- OFFSET_BITS, 3, byte-offset bits within a way; must be >= 3.
- LANE_W, 8*(2**OFFSET_BITS)*(2**LOG_WAYS), lane width (derived, not overridden).
- Derived: WAY_W = 8*2^OFFSET_BITS; W = 2^(OFFSET_BITS-2) words per way.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_lane  in  LANE_W  full lane, way k at bits [k*WAY_W +: WAY_W].
- req_pos  in  LOG_WAYS  way select.
- req_offset  in  OFFSET_BITS  byte offset within the way.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend (byte/half only).
- req_burst_len  in  OFFSET_BITS-2  beats minus one (word size only).
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  consumer accepts the beat.
- rsp_data  out  32  response word.
- rsp_last  out  1  final beat of the request.
- rsp_err  out  1  misaligned request; rsp_data = 0.

Behaviour:
- Reset (async, any time): state IDLE, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, beat counter 0, req_ready=1 once reset deasserts.
- States: IDLE, STREAM.
- req_ready = 1 only in IDLE.
- Accept when req_valid && req_ready. On accept:
  - register only the selected WAY_W slice, word index = req_offset[OFFSET_BITS-1:2], and size/unsigned/burst fields;
  - go to STREAM.
- Latency: first beat has rsp_valid=1 on the cycle after accept. The lane input is not needed after the accept cycle.
- Misalignment: half with offset[0]=1, or word with offset[1:0]!=0 → single beat, rsp_err=1, rsp_data=0, rsp_last=1.
- Byte beat: byte at offset, bits [7:0], extended per req_unsigned. Half beat: bytes offset+1:offset, little-endian, extended. Both are single beat with rsp_last=1, and req_burst_len is ignored.
- Word beat k (k = 0..burst_len): word index (start + k) mod W, little-endian. The index wraps inside the selected way and never crosses into another way.
- rsp_last=1 exactly on beat burst_len.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data/rsp_last/rsp_err are held stable and the counter does not advance.
- On rsp_valid && rsp_ready:
  - if not last, the next beat is presented the following cycle;
  - if last, rsp_valid=0 next cycle and state returns to IDLE.
- Throughput: one beat per cycle while rsp_ready=1. One IDLE bubble between requests; no accept in the last-beat cycle.
- req_size=11 is handled identically to 10.
- burst_len = W-1 streams the whole way exactly once.

Test Plan:
- Defaults, lane byte i = i (0x00..0x1F); word, pos=2, offset=4 → one beat, rsp_data=0x17161514, rsp_last=1, rsp_err=0, rsp_valid one cycle after accept.
- Defaults, way1 byte5 = 0x85; byte, pos=1, offset=5, signed → 0xFFFFFF85; same request unsigned → 0x00000085. Half at offset 4, signed, with bytes 0x85,0x0C → 0xFFFF850C.
- OFFSET_BITS=4, way0 words = 0xA0,0xA1,0xA2,0xA3; word, offset=8, burst_len=3 → beats 0xA2, 0xA3, 0xA0, 0xA1 on consecutive cycles; rsp_last only on 4th; req_ready=1 the cycle after.
- Same burst with rsp_ready low for 3 cycles on beat 2 → 0xA3 held stable, no beat dropped or repeated, total 4 beats.
- Word at offset=2 → single beat, rsp_err=1, rsp_data=0, rsp_last=1; half at offset=1 → same.
- Assert reset asynchronously mid-burst (after beat 1) → rsp_valid=0 immediately, req_ready=1 after release; next request streams correctly from its own offset.
